medidor_periodo: RTL and testbench
==================================

# medidor_periodo

Input front-end for the external-signal PWM. It synchronises an asynchronous external square wave to `clock` and detects its rising edges. It measures the period in clock cycles and publishes the period, the 1/16 duty step and a one-cycle period-start strobe. The downstream PWM stage consumes these outputs directly. It never samples the raw pin or divides by itself.

## Interface
Parameters:
- `WIDTH`, 32: width of the period counter and of `o_periodo`.
- `MAX_PERIOD`, 2**WIDTH-1: counter saturation value; reaching it declares the input lost.
- `FILTER_LEN`, 4: stability length in cycles for the glitch filter. Used only when `MEDIDOR_FILTRO_EN` is defined.

Ports:
- `clock`  in  1: single clock. All logic is on the rising edge.
- `reset`  in  1: **synchronous, active-high** reset.
- `i_signal`  in  1: external square wave, asynchronous to `clock`.
- `o_inicio`  out  1: one-cycle strobe at each accepted rising edge. This is the PWM period start.
- `o_valid`  out  1: one-cycle strobe when `o_periodo` and `o_resolucion` are updated with a new measurement.
- `o_periodo`  out  WIDTH: last measured period, in clock cycles.
- `o_resolucion`  out  WIDTH-4: `o_periodo >> 4`, the PWM duty step.
- `o_timeout`  out  1: level. High while no edge has arrived for `MAX_PERIOD` cycles.

## Operation
- Synchroniser: 2-FF chain, followed by a registered copy used for rising-edge detection (`sync==1 && prev==0`).
- FSM states:
  - IDLE: the reset state, and the state after a timeout. An edge moves the FSM to PRIMERO, asserts `o_inicio` and loads the counter with 1.
  - PRIMERO: the counter increments each cycle. The next edge moves the FSM to MIDIENDO, captures the count into `o_periodo`, pulses `o_valid` and `o_inicio`, and reloads the counter with 1.
  - MIDIENDO: same edge action as PRIMERO. The FSM stays in MIDIENDO.
- Period arithmetic: the captured value equals the number of clock cycles between consecutive detected edges. Example: an input period of 10 clocks gives `o_periodo`=10.
  - `o_resolucion` is a plain truncating shift, with no rounding.
- Saturation: in PRIMERO or MIDIENDO, a counter value of `MAX_PERIOD` without an edge triggers the timeout. On timeout:
  - the counter holds its value;
  - `o_timeout` goes to 1;
  - `o_periodo` and `o_resolucion` are cleared to 0;
  - the FSM goes to IDLE;
  - no `o_valid` pulse is produced.
- `o_timeout` clears on the next accepted edge.
- An edge in the same cycle the counter reaches `MAX_PERIOD` counts as an edge. The capture happens and no timeout occurs.
- Reset values: `o_inicio`=0, `o_valid`=0, `o_periodo`=0, `o_resolucion`=0, `o_timeout`=0, FSM=IDLE, counter=0. All synchroniser flops are 0.
- Reset mid-measurement discards the partial count. The first edge after reset yields only `o_inicio`, never `o_valid`.

## Timing
- Latency: if `i_signal` is first sampled high at clock edge k, `o_inicio` is high during the cycle following edge k+3. The breakdown is 2 sync stages, 1 edge register and 1 output register.
- `o_valid`, `o_periodo` and `o_resolucion` update in the same cycle as `o_inicio`. `o_resolucion` is registered together with `o_periodo`, with no extra cycle.
- The minimum resolvable input period is 2 clocks, with high and low each at least 1 clock. Shorter pulses may be missed. This is not an error condition.
- Outputs hold their values between `o_valid` strobes.

## Configuration
- `MEDIDOR_FILTRO_EN` defined: a glitch filter is inserted after the synchroniser. The filtered level changes only after the synchronised input holds the new level for `FILTER_LEN` consecutive cycles. This adds `FILTER_LEN` cycles to the `o_inicio` latency. Shorter pulses are ignored entirely.
- `MEDIDOR_FILTRO_EN` undefined: no filter. `FILTER_LEN` has no effect. The latency is exactly as given under Timing.

## Structure
- Shared package `medidor_pkg`:
  - FSM state encoding (IDLE, PRIMERO, MIDIENDO);
  - the default `WIDTH`;
  - the constant 4 for the resolution shift, which the PWM stage shares.
- Sub-module `sincronizador_flanco`: the 2-FF synchroniser, the optional filter and the rising-edge pulse. It outputs a single-cycle `flanco`. The FSM and counter stay in `medidor_periodo`.

## Test plan
- Square wave with period 10 clocks, 3 periods → first `o_valid` at the second edge, with `o_periodo`=10 and `o_resolucion`=0. `o_inicio` pulses on every edge.
- Period 160 clocks → `o_periodo`=160, `o_resolucion`=10. Switching the input to period 48 → next capture gives 48 and 3.
- `MAX_PERIOD`=100, input held low after one edge → `o_timeout`=1 exactly 100 cycles after the edge, with `o_periodo`=0. A later edge clears `o_timeout` and does not produce `o_valid`.
- `reset` asserted for 1 cycle midway through a 50-clock period → all outputs 0. The next edge gives `o_inicio` only; the following edge gives `o_periodo`=50.
- 1-cycle high glitch inside a 40-clock wave:
  - with `MEDIDOR_FILTRO_EN` and `FILTER_LEN`=4 → ignored, and `o_periodo` stays 40;
  - without the macro → two short periods are captured, and their sum is 40.
- Edge arriving in the cycle the counter hits `MAX_PERIOD` → captured as the period, with `o_timeout` staying 0.

Source files
------------

// File: rtl/medidor_pkg.sv
// Shared definitions for the period meter and the PWM stage that consumes it.
package medidor_pkg;
  localparam int WIDTH_DEF = 32;
  // Duty step is period/16; the PWM stage uses the same shift.
  localparam int RES_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIMERO  = 2'd1,
    MIDIENDO = 2'd2
  } estado_t;
endpackage

// File: rtl/medidor_periodo_if.sv
// Measurement bus from medidor_periodo to the PWM stage.
interface medidor_periodo_if
  import medidor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic                     o_inicio;
  logic                     o_valid;
  logic [WIDTH-1:0]         o_periodo;
  logic [WIDTH-RES_SHIFT-1:0] o_resolucion;
  logic                     o_timeout;

  modport master (output o_inicio, o_valid, o_periodo, o_resolucion, o_timeout);
  modport slave  (input  o_inicio, o_valid, o_periodo, o_resolucion, o_timeout);
endinterface

// File: rtl/sincronizador_flanco.sv
// 2-FF synchroniser plus registered rising-edge pulse for the external signal.
// Optional glitch filter between synchroniser and edge detector: MEDIDOR_FILTRO_EN.
module sincronizador_flanco #(
  parameter int FILTER_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic senal,
  output logic flanco
);
  logic s1, s2, nivel, prev;

`ifdef MEDIDOR_FILTRO_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] estable;

  // Level follows s2 only after s2 has differed for FILTER_LEN straight cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      nivel   <= 1'b0;
      estable <= '0;
    end else if (s2 == nivel) begin
      estable <= '0;
    end else if (estable == CW'(FILTER_LEN - 1)) begin
      nivel   <= s2;
      estable <= '0;
    end else begin
      estable <= estable + 1'b1;
    end
  end
`else
  logic unused_filter_len;
  assign unused_filter_len = (FILTER_LEN != 0);
  assign nivel = s2;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      prev   <= 1'b0;
      flanco <= 1'b0;
    end else begin
      s1     <= senal;
      s2     <= s1;
      prev   <= nivel;
      flanco <= nivel & ~prev;
    end
  end
endmodule

// File: rtl/medidor_periodo.sv
// Period meter: counts clocks between rising edges of i_signal and publishes period,
// period>>4 and a period-start strobe. Glitch filter option: MEDIDOR_FILTRO_EN.
module medidor_periodo
  import medidor_pkg::*;
#(
  parameter int               WIDTH      = WIDTH_DEF,
  parameter logic [WIDTH-1:0] MAX_PERIOD = {WIDTH{1'b1}},
  parameter int               FILTER_LEN = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_signal,
  medidor_periodo_if.master   bus
);
  estado_t                    estado, estado_nx;
  logic [WIDTH-1:0]           cnt, cnt_nx, periodo, periodo_nx;
  logic [WIDTH-RES_SHIFT-1:0] resol;
  logic                       inicio, inicio_nx, valid, valid_nx, timeout, timeout_nx;
  logic                       flanco;

  sincronizador_flanco #(.FILTER_LEN(FILTER_LEN)) u_sinc (
    .clock  (clock),
    .reset  (reset),
    .senal  (i_signal),
    .flanco (flanco)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= IDLE;
      cnt     <= '0;
      periodo <= '0;
      resol   <= '0;
      inicio  <= 1'b0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      estado  <= estado_nx;
      cnt     <= cnt_nx;
      periodo <= periodo_nx;
      resol   <= periodo_nx[WIDTH-1:RES_SHIFT];
      inicio  <= inicio_nx;
      valid   <= valid_nx;
      timeout <= timeout_nx;
    end
  end

  always_comb begin
    estado_nx  = estado;
    cnt_nx     = cnt;
    periodo_nx = periodo;
    inicio_nx  = 1'b0;
    valid_nx   = 1'b0;
    timeout_nx = timeout;
    unique case (estado)
      IDLE: begin
        if (flanco) begin
          estado_nx  = PRIMERO;
          cnt_nx     = WIDTH'(1);
          inicio_nx  = 1'b1;
          timeout_nx = 1'b0;
        end
      end
      PRIMERO, MIDIENDO: begin
        // An edge wins over saturation in the same cycle.
        if (flanco) begin
          estado_nx  = MIDIENDO;
          periodo_nx = cnt;
          cnt_nx     = WIDTH'(1);
          inicio_nx  = 1'b1;
          valid_nx   = 1'b1;
          timeout_nx = 1'b0;
        end else if (cnt == MAX_PERIOD) begin
          estado_nx  = IDLE;
          periodo_nx = '0;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: estado_nx = IDLE;
    endcase
  end

  assign bus.o_inicio     = inicio;
  assign bus.o_valid      = valid;
  assign bus.o_periodo    = periodo;
  assign bus.o_resolucion = resol;
  assign bus.o_timeout    = timeout;
endmodule

// File: tb/tb_medidor_periodo.sv
// Directed bench for medidor_periodo: one wide-saturation instance and one with MAX_PERIOD=100.
module tb_medidor_periodo;
  import medidor_pkg::*;
  localparam int W  = 16;
  localparam int FL = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic i_signal = 1'b0;
  always #5 clock = ~clock;

  medidor_periodo_if #(.WIDTH(W)) bus_a ();
  medidor_periodo_if #(.WIDTH(W)) bus_b ();

  medidor_periodo #(.WIDTH(W), .FILTER_LEN(FL)) dut_a (
    .clock(clock), .reset(reset), .i_signal(i_signal), .bus(bus_a));
  medidor_periodo #(.WIDTH(W), .MAX_PERIOD(16'd100), .FILTER_LEN(FL)) dut_b (
    .clock(clock), .reset(reset), .i_signal(i_signal), .bus(bus_b));

  int checks = 0, failures = 0;

  // Monitor: observes strobes on the falling edge.
  int cyc = 0, n_ini_a = 0, n_val_a = 0, n_val_b = 0, n_to_b = 0;
  int last_ini_b = 0, to_rise_b = 0;
  logic to_prev_b = 1'b0;
  logic [W-1:0] last_per_a = '0, last_per_b = '0;
  logic [W-5:0] last_res_a = '0;
  logic [W-1:0] hist_a[$];

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      to_prev_b = 1'b0;
    end else begin
      if (bus_a.o_inicio) n_ini_a++;
      if (bus_a.o_valid) begin
        n_val_a++;
        last_per_a = bus_a.o_periodo;
        last_res_a = bus_a.o_resolucion;
        hist_a.push_back(bus_a.o_periodo);
      end
      if (bus_b.o_inicio) last_ini_b = cyc;
      if (bus_b.o_valid) begin
        n_val_b++;
        last_per_b = bus_b.o_periodo;
      end
      if (bus_b.o_timeout && !to_prev_b) to_rise_b = cyc;
      if (bus_b.o_timeout) n_to_b++;
      to_prev_b = bus_b.o_timeout;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge; v is sampled at the next n rising edges.
  task automatic hold(input logic v, input int n);
    i_signal = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic square(input int p, input int n);
    repeat (n) begin
      hold(1'b1, p / 2);
      hold(1'b0, p - p / 2);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold(1'b0, 3);
    reset = 1'b0;
    hold(1'b0, 3);
  endtask

  typedef struct {
    int           per;
    int           reps;
    logic [W-1:0] exp_per;
    logic [W-5:0] exp_res;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int v0, i0, s0, t0;
    logic [11:0] lat;
    vecs[0] = '{160, 2, 16'd160, 12'd10};
    vecs[1] = '{48,  2, 16'd48,  12'd3};
    vecs[2] = '{17,  2, 16'd17,  12'd1};
    vecs[3] = '{33,  2, 16'd33,  12'd2};
    vecs[4] = '{16,  2, 16'd16,  12'd1};
    vecs[5] = '{15,  2, 16'd15,  12'd0};
    vecs[6] = '{255, 2, 16'd255, 12'd15};
    vecs[7] = '{8,   3, 16'd8,   12'd0};

    // Reset state
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_inicio",  bus_a.o_inicio, 0);
    chk("rst_valid",   bus_a.o_valid, 0);
    chk("rst_periodo", bus_a.o_periodo, 0);
    chk("rst_resol",   bus_a.o_resolucion, 0);
    chk("rst_timeout", bus_a.o_timeout, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    hold(1'b0, 3);

    // Period 10, three periods: valid from the second edge on
    square(10, 3);
    chk("p10_inicios", n_ini_a, 3);
    chk("p10_valids",  n_val_a, 2);
    chk("p10_periodo", last_per_a, 10);
    chk("p10_resol",   last_res_a, 0);

    // Table of periods, continuous waveform
    for (int i = 0; i < 8; i++) begin
      square(vecs[i].per, vecs[i].reps);
      chk($sformatf("tab%0d_periodo", vecs[i].per), last_per_a, vecs[i].exp_per);
      chk($sformatf("tab%0d_resol", vecs[i].per), last_res_a, vecs[i].exp_res);
    end

`ifndef MEDIDOR_FILTRO_EN
    // Minimum resolvable period: 1 high, 1 low
    v0 = n_val_a;
    square(2, 6);
    hold(1'b0, 8);
    chk("p2_periodo", last_per_a, 2);
    chk("p2_valids", n_val_a - v0, 6);
`endif

    // Latency: first sampled high at edge k -> o_inicio in cycle after k+3
    do_reset();
    i_signal = 1'b1;
    lat = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      lat[i] = bus_a.o_inicio;
    end
`ifdef MEDIDOR_FILTRO_EN
    chk("latency_map", lat, 12'b1 << (4 + FL));
`else
    chk("latency_map", lat, 12'b1 << 4);
`endif
    @(posedge clock); #1;
    hold(1'b1, 10);
    hold(1'b0, 20);

    // Reset in the middle of a 50-clock period
    do_reset();
    hold(1'b1, 25); hold(1'b0, 25);
    hold(1'b1, 25); hold(1'b0, 12);
    reset = 1'b1;
    hold(1'b0, 1);
    @(negedge clock);
    chk("midrst_inicio",  bus_a.o_inicio, 0);
    chk("midrst_valid",   bus_a.o_valid, 0);
    chk("midrst_periodo", bus_a.o_periodo, 0);
    chk("midrst_resol",   bus_a.o_resolucion, 0);
    chk("midrst_timeout", bus_a.o_timeout, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    v0 = n_val_a; i0 = n_ini_a;
    hold(1'b0, 11);
    square(50, 1);
    chk("midrst_first_inicio", n_ini_a - i0, 1);
    chk("midrst_first_novalid", n_val_a - v0, 0);
    square(50, 1);
    chk("midrst_second_valid", n_val_a - v0, 1);
    chk("midrst_periodo50", last_per_a, 50);

    // One-cycle glitch inside a 40-clock wave
    do_reset();
    hold(1'b1, 20); hold(1'b0, 20);
    v0 = n_val_a; s0 = hist_a.size();
    hold(1'b1, 20); hold(1'b0, 10); hold(1'b1, 1); hold(1'b0, 9);
    hold(1'b1, 20); hold(1'b0, 20);
`ifdef MEDIDOR_FILTRO_EN
    chk("glitch_valids", n_val_a - v0, 2);
    chk("glitch_last", hist_a[hist_a.size()-1], 40);
    chk("glitch_prev", hist_a[hist_a.size()-2], 40);
`else
    chk("glitch_valids", n_val_a - v0, 3);
    chk("glitch_short1", hist_a[hist_a.size()-2], 30);
    chk("glitch_short2", hist_a[hist_a.size()-1], 10);
    chk("glitch_sum", hist_a[hist_a.size()-2] + hist_a[hist_a.size()-1], 40);
`endif
    chk("glitch_hist_grew", hist_a.size() > s0, 1);

    // Timeout with MAX_PERIOD=100 on dut_b
    do_reset();
    hold(1'b1, 30); hold(1'b0, 30);
    hold(1'b1, 30);
    v0 = n_val_b;
    chk("to_pre_periodo", last_per_b, 60);
    hold(1'b0, 120);
    chk("to_distance", to_rise_b - last_ini_b, 100);
    chk("to_level", bus_b.o_timeout, 1);
    chk("to_periodo_clr", bus_b.o_periodo, 0);
    chk("to_resol_clr", bus_b.o_resolucion, 0);
    chk("to_no_valid", n_val_b - v0, 0);

    // Later edge clears timeout without o_valid; next edge exactly at MAX_PERIOD
    hold(1'b1, 50);
    chk("to_clear", bus_b.o_timeout, 0);
    chk("to_clear_novalid", n_val_b - v0, 0);
    t0 = n_to_b;
    hold(1'b0, 50);
    hold(1'b1, 50);
    chk("max_edge_valid", n_val_b - v0, 1);
    chk("max_edge_periodo", last_per_b, 100);
    chk("max_edge_no_timeout", n_to_b - t0, 0);

    // One cycle longer than MAX_PERIOD saturates instead
    hold(1'b0, 51);
    hold(1'b1, 50);
    chk("max_plus1_timeout_seen", n_to_b > t0, 1);
    chk("max_plus1_valid", n_val_b - v0, 1);
    hold(1'b0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
